// File: rtl/rice_csr_pkg.sv
// Shared definitions for the RICE CSR counter block: privilege levels,
// counter bit positions inside mcounteren/mcountinhibit, and counter width.
package rice_csr_pkg;

  typedef enum logic [1:0] {
    PRIV_U = 2'b00,
    PRIV_S = 2'b01,
    PRIV_M = 2'b11
  } priv_e;

  // Bit positions of the implemented counters in mcounteren/mcountinhibit.
  localparam int CY_BIT = 0;
  localparam int IR_BIT = 2;

  // Width of each hardware counter.
  localparam int CNT_W = 64;

  // Only CY and IR are implemented; every other bit reads back as zero.
  localparam logic [31:0] IMPL_MASK = (32'h1 << CY_BIT) | (32'h1 << IR_BIT);

endpackage

// File: rtl/rice_csr_counter_unit.sv
// One 64-bit CSR counter with independent low/high half writes.
// Writes win over the increment; simultaneous half writes load both halves.
module rice_csr_counter_unit
  import rice_csr_pkg::*;
#(
  parameter logic [CNT_W-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic [31:0]      wdata,
  input  logic             we_lo,
  input  logic             we_hi,
  output logic [CNT_W-1:0] value
);

  logic [CNT_W-1:0] written;

  // Merge write data into whichever halves are strobed, keep the other half.
  always_comb begin
    written = value;
    if (we_lo) written[31:0]       = wdata;
    if (we_hi) written[CNT_W-1:32] = wdata;
  end

  // Counter state: reset, then write, then full-width increment (carry in one cycle).
  always_ff @(posedge clk) begin
    if (rst) begin
      value <= RESET_VALUE;
    end else if (we_lo || we_hi) begin
      value <= written;
    end else if (inc) begin
      value <= value + 1'b1;
    end
  end

endmodule

// File: rtl/rice_csr_counter.sv
// Top of the RICE CSR counter block: cycle and instret counters, the
// mcounteren/mcountinhibit registers and the U-level read permissions.
// Both halves of a counter come from one register, so they are always coherent.
module rice_csr_counter
  import rice_csr_pkg::*;
#(
  parameter logic [63:0] CYCLE_RESET_VALUE   = 64'h0,
  parameter logic [63:0] INSTRET_RESET_VALUE = 64'h0
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_retire,
  input  logic [1:0]  i_priv,
  input  logic [31:0] i_wdata,
  input  logic        i_mcycle_we,
  input  logic        i_mcycleh_we,
  input  logic        i_minstret_we,
  input  logic        i_minstreth_we,
  input  logic        i_mcounteren_we,
  input  logic        i_mcountinhibit_we,
  output logic [31:0] o_cycle,
  output logic [31:0] o_cycleh,
  output logic [31:0] o_instret,
  output logic [31:0] o_instreth,
  output logic        o_cycle_read_enable,
  output logic        o_instret_read_enable,
  output logic [31:0] o_mcounteren,
  output logic [31:0] o_mcountinhibit
);

  logic [31:0]      mcounteren;
  logic [31:0]      mcountinhibit;
  logic [CNT_W-1:0] cycle_value;
  logic [CNT_W-1:0] instret_value;
  logic             cycle_inc;
  logic             instret_inc;
  logic             is_machine;

  // Enable/inhibit registers; unimplemented bits are masked off on write.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      mcounteren    <= '0;
      mcountinhibit <= '0;
    end else begin
      if (i_mcounteren_we)    mcounteren    <= i_wdata & IMPL_MASK;
      if (i_mcountinhibit_we) mcountinhibit <= i_wdata & IMPL_MASK;
    end
  end

  // Increment requests use the registered inhibit, i.e. the value before any write this cycle.
  always_comb begin
    cycle_inc   = ~mcountinhibit[CY_BIT];
    instret_inc = i_retire & ~mcountinhibit[IR_BIT];
  end

  rice_csr_counter_unit #(
    .RESET_VALUE (CYCLE_RESET_VALUE)
  ) u_cycle (
    .clk   (i_clk),
    .rst   (i_rst),
    .inc   (cycle_inc),
    .wdata (i_wdata),
    .we_lo (i_mcycle_we),
    .we_hi (i_mcycleh_we),
    .value (cycle_value)
  );

  rice_csr_counter_unit #(
    .RESET_VALUE (INSTRET_RESET_VALUE)
  ) u_instret (
    .clk   (i_clk),
    .rst   (i_rst),
    .inc   (instret_inc),
    .wdata (i_wdata),
    .we_lo (i_minstret_we),
    .we_hi (i_minstreth_we),
    .value (instret_value)
  );

  // Read permission is combinational from current privilege and registered enables.
  always_comb begin
    is_machine            = (i_priv == PRIV_M);
    o_cycle_read_enable   = is_machine | mcounteren[CY_BIT];
    o_instret_read_enable = is_machine | mcounteren[IR_BIT];
  end

  // Output mapping of counter halves and read-back registers.
  always_comb begin
    o_cycle         = cycle_value[31:0];
    o_cycleh        = cycle_value[CNT_W-1:32];
    o_instret       = instret_value[31:0];
    o_instreth      = instret_value[CNT_W-1:32];
    o_mcounteren    = mcounteren;
    o_mcountinhibit = mcountinhibit;
  end

endmodule

// File: tb/tb_rice_csr_counter.sv
// Bench for rice_csr_counter: directed vector table, a hand-written
// 10-clock reset-release sequence, then randomized traffic against a model.
module tb_rice_csr_counter;

  logic        clk;
  logic        rst;
  logic        retire;
  logic [1:0]  priv;
  logic [31:0] wdata;
  logic        mcycle_we, mcycleh_we, minstret_we, minstreth_we;
  logic        mcounteren_we, mcountinhibit_we;
  logic [31:0] cycle_lo, cycle_hi, instret_lo, instret_hi;
  logic        cycle_re, instret_re;
  logic [31:0] mcounteren, mcountinhibit;

  int total = 0;
  int bad   = 0;

  // Reference model state, in plain 64-bit arithmetic.
  logic [63:0] m_cyc, m_ins;
  logic [31:0] m_en, m_inh;

  rice_csr_counter dut (
    .i_clk                 (clk),
    .i_rst                 (rst),
    .i_retire              (retire),
    .i_priv                (priv),
    .i_wdata               (wdata),
    .i_mcycle_we           (mcycle_we),
    .i_mcycleh_we          (mcycleh_we),
    .i_minstret_we         (minstret_we),
    .i_minstreth_we        (minstreth_we),
    .i_mcounteren_we       (mcounteren_we),
    .i_mcountinhibit_we    (mcountinhibit_we),
    .o_cycle               (cycle_lo),
    .o_cycleh              (cycle_hi),
    .o_instret             (instret_lo),
    .o_instreth            (instret_hi),
    .o_cycle_read_enable   (cycle_re),
    .o_instret_read_enable (instret_re),
    .o_mcounteren          (mcounteren),
    .o_mcountinhibit       (mcountinhibit)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Vector record: we = {mcycle, mcycleh, minstret, minstreth, mcounteren, mcountinhibit}
  typedef struct {
    logic        rst;
    logic        retire;
    logic [1:0]  priv;
    logic [31:0] wdata;
    logic [5:0]  we;
    logic [63:0] exp_cyc;
    logic [63:0] exp_ins;
    logic [31:0] exp_en;
    logic [31:0] exp_inh;
    logic        exp_cre;
    logic        exp_ire;
  } vec_t;

  vec_t tv[19];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic ret, input logic [1:0] p,
                       input logic [31:0] wd, input logic [5:0] we);
    rst              = r;
    retire           = ret;
    priv             = p;
    wdata            = wd;
    mcycle_we        = we[5];
    mcycleh_we       = we[4];
    minstret_we      = we[3];
    minstreth_we     = we[2];
    mcounteren_we    = we[1];
    mcountinhibit_we = we[0];
  endtask

  // One clock: model computes next state from the current inputs, then the edge.
  task automatic tick();
    logic [63:0] n_cyc, n_ins;
    logic [31:0] n_en, n_inh;
    if (rst) begin
      n_cyc = 64'h0; n_ins = 64'h0; n_en = 32'h0; n_inh = 32'h0;
    end else begin
      n_en  = mcounteren_we    ? (wdata & 32'h5) : m_en;
      n_inh = mcountinhibit_we ? (wdata & 32'h5) : m_inh;
      if (mcycle_we || mcycleh_we)
        n_cyc = {mcycleh_we ? wdata : m_cyc[63:32], mcycle_we ? wdata : m_cyc[31:0]};
      else
        n_cyc = m_cyc + (m_inh[0] ? 64'd0 : 64'd1);
      if (minstret_we || minstreth_we)
        n_ins = {minstreth_we ? wdata : m_ins[63:32], minstret_we ? wdata : m_ins[31:0]};
      else
        n_ins = m_ins + ((retire && !m_inh[2]) ? 64'd1 : 64'd0);
    end
    @(posedge clk);
    #1;
    m_cyc = n_cyc; m_ins = n_ins; m_en = n_en; m_inh = n_inh;
  endtask

  task automatic check_model(input string tag);
    chk({tag, " cycle"},   {cycle_hi, cycle_lo}, m_cyc);
    chk({tag, " instret"}, {instret_hi, instret_lo}, m_ins);
    chk({tag, " en"},      {32'h0, mcounteren}, {32'h0, m_en});
    chk({tag, " inh"},     {32'h0, mcountinhibit}, {32'h0, m_inh});
    chk({tag, " cre"},     {63'h0, cycle_re},   {63'h0, (priv == 2'b11) | m_en[0]});
    chk({tag, " ire"},     {63'h0, instret_re}, {63'h0, (priv == 2'b11) | m_en[2]});
  endtask

  initial begin
    logic [5:0]  we;
    logic [31:0] wd;
    m_cyc = '0; m_ins = '0; m_en = '0; m_inh = '0;
    drive(1'b1, 1'b0, 2'b11, 32'h0, 6'b0);

    //          rst   ret   priv   wdata          we        exp_cyc                 exp_ins   en     inh    cre ire
    tv[0]  = '{1'b1, 1'b0, 2'b11, 32'h0,         6'b000000, 64'h0,                  64'd0,    32'h0, 32'h0, 1, 1};
    tv[1]  = '{1'b0, 1'b0, 2'b00, 32'h0,         6'b000000, 64'd1,                  64'd0,    32'h0, 32'h0, 0, 0};
    tv[2]  = '{1'b0, 1'b0, 2'b00, 32'hFFFF_FFFE, 6'b100000, 64'h0000_0000_FFFF_FFFE, 64'd0,   32'h0, 32'h0, 0, 0};
    tv[3]  = '{1'b0, 1'b0, 2'b00, 32'h0,         6'b000000, 64'h0000_0000_FFFF_FFFF, 64'd0,   32'h0, 32'h0, 0, 0};
    tv[4]  = '{1'b0, 1'b0, 2'b00, 32'h0,         6'b000000, 64'h0000_0001_0000_0000, 64'd0,   32'h0, 32'h0, 0, 0};
    tv[5]  = '{1'b0, 1'b0, 2'b00, 32'hFFFF_FFFF, 6'b110000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0,   32'h0, 32'h0, 0, 0};
    tv[6]  = '{1'b0, 1'b0, 2'b00, 32'h0,         6'b000000, 64'h0,                  64'd0,    32'h0, 32'h0, 0, 0};
    tv[7]  = '{1'b0, 1'b1, 2'b00, 32'd5,         6'b001000, 64'd1,                  64'd5,    32'h0, 32'h0, 0, 0};
    tv[8]  = '{1'b0, 1'b1, 2'b00, 32'h0,         6'b000000, 64'd2,                  64'd6,    32'h0, 32'h0, 0, 0};
    tv[9]  = '{1'b0, 1'b0, 2'b00, 32'hFFFF_FFFF, 6'b000010, 64'd3,                  64'd6,    32'h5, 32'h0, 1, 1};
    tv[10] = '{1'b0, 1'b0, 2'b00, 32'h0,         6'b000010, 64'd4,                  64'd6,    32'h0, 32'h0, 0, 0};
    tv[11] = '{1'b0, 1'b0, 2'b11, 32'h0,         6'b000000, 64'd5,                  64'd6,    32'h0, 32'h0, 1, 1};
    tv[12] = '{1'b0, 1'b1, 2'b11, 32'hFFFF_FFFF, 6'b000001, 64'd6,                  64'd7,    32'h0, 32'h5, 1, 1};
    tv[13] = '{1'b0, 1'b1, 2'b11, 32'h0,         6'b000000, 64'd6,                  64'd7,    32'h0, 32'h5, 1, 1};
    tv[14] = '{1'b0, 1'b0, 2'b11, 32'd3,         6'b010000, 64'h0000_0003_0000_0006, 64'd7,   32'h0, 32'h5, 1, 1};
    tv[15] = '{1'b0, 1'b1, 2'b11, 32'h0,         6'b000001, 64'h0000_0003_0000_0006, 64'd7,   32'h0, 32'h0, 1, 1};
    tv[16] = '{1'b0, 1'b1, 2'b11, 32'h0,         6'b000000, 64'h0000_0003_0000_0007, 64'd8,   32'h0, 32'h0, 1, 1};
    tv[17] = '{1'b1, 1'b1, 2'b00, 32'd9,         6'b111111, 64'h0,                  64'd0,    32'h0, 32'h0, 0, 0};
    tv[18] = '{1'b0, 1'b0, 2'b00, 32'h0,         6'b000000, 64'd1,                  64'd0,    32'h0, 32'h0, 0, 0};

    // Directed vector table
    for (int i = 0; i < 19; i++) begin
      drive(tv[i].rst, tv[i].retire, tv[i].priv, tv[i].wdata, tv[i].we);
      tick();
      chk($sformatf("v%0d cycle", i),   {cycle_hi, cycle_lo},     tv[i].exp_cyc);
      chk($sformatf("v%0d instret", i), {instret_hi, instret_lo}, tv[i].exp_ins);
      chk($sformatf("v%0d en", i),      {32'h0, mcounteren},      {32'h0, tv[i].exp_en});
      chk($sformatf("v%0d inh", i),     {32'h0, mcountinhibit},   {32'h0, tv[i].exp_inh});
      chk($sformatf("v%0d cre", i),     {63'h0, cycle_re},        {63'h0, tv[i].exp_cre});
      chk($sformatf("v%0d ire", i),     {63'h0, instret_re},      {63'h0, tv[i].exp_ire});
    end

    // Reset release followed by 10 idle clocks
    drive(1'b1, 1'b0, 2'b00, 32'h0, 6'b0);
    tick();
    tick();
    drive(1'b0, 1'b0, 2'b00, 32'h0, 6'b0);
    for (int i = 0; i < 10; i++) tick();
    chk("rel10 cycle",    {32'h0, cycle_lo},   64'd10);
    chk("rel10 cycleh",   {32'h0, cycle_hi},   64'd0);
    chk("rel10 instret",  {32'h0, instret_lo}, 64'd0);
    check_model("rel10");

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      we = 6'b0;
      for (int b = 0; b < 6; b++) we[b] = ($urandom_range(0, 9) == 0);
      case ($urandom_range(0, 3))
        0:       wd = 32'hFFFF_FFFF - $urandom_range(0, 3);
        1:       wd = $urandom_range(0, 7);
        default: wd = $urandom;
      endcase
      drive($urandom_range(0, 99) == 0, $urandom_range(0, 1) == 1,
            2'($urandom_range(0, 3)), wd, we);
      tick();
      check_model($sformatf("rnd%0d", n));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
